spram_rr_arbiter: RTL
=====================

Name: spram_rr_arbiter

Overview:
- Shares one single-port block RAM (1-cycle read latency; read data updates only on non-write cycles) between two requesters, A and B.
- Arbitration is round-robin, one access per cycle. Each requester uses a valid/ready request handshake and gets a fixed-latency read response.
- An optional post-reset sequencer zero-fills the RAM before any requester is served.
- Sits between the Montgomery/modexp datapath engines and their shared operand RAM.

Parameters:
WIDTH_DATA, 128, data word width in bits
DEPTH, 64, RAM depth in words; power of two, at least 2
INIT_CLEAR, 1, 1 = zero-fill all DEPTH words after reset; 0 = skip straight to arbitration

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
a_req_valid  input  1  requester A access request
a_req_ready  output  1  A request accepted this cycle
a_req_wen  input  1  1 = write, 0 = read
a_req_addr  input  $clog2(DEPTH)  A address
a_req_wdata  input  WIDTH_DATA  A write data
a_rsp_valid  output  1  A read data valid
a_rsp_data  output  WIDTH_DATA  A read data
b_req_valid, b_req_ready, b_req_wen, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_data  as for A
ram_wen  output  1  to RAM write enable
ram_addr  output  $clog2(DEPTH)  to RAM address
ram_wr_data  output  WIDTH_DATA  to RAM write data
ram_rd_data  input  WIDTH_DATA  from RAM read data
init_done  output  1  high once arbitration is active

Behaviour:
- States: INIT, ARB.
- Reset (rst_n=0 at posedge) sets registers as follows:
  - state = INIT if INIT_CLEAR=1, else ARB
  - init_cnt = 0; prio = A
  - a_rsp_valid = b_rsp_valid = 0; init_done = 0 (1 if INIT_CLEAR=0)
- Reset mid-operation: in-flight read responses are dropped, with no rsp_valid the following cycle. The INIT fill restarts from address 0.
- INIT:
  - ram_wen=1, ram_addr=init_cnt, ram_wr_data=0.
  - Both req_ready=0; requests are ignored (requesters hold them).
  - init_cnt increments each cycle. On the cycle init_cnt=DEPTH-1, next state is ARB and init_done goes 1 on the following cycle.
  - INIT lasts exactly DEPTH cycles.
- ARB grant logic (combinational from current inputs and prio):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the side named by prio.
  - Neither valid -> no grant.
- Grant outputs:
  - Granted side's req_ready=1; the other side's req_ready=0. The handshake completes in the same cycle (valid && ready).
  - ram_wen, ram_addr, ram_wr_data are driven combinationally from the granted requester.
  - No grant: ram_wen=0, ram_addr=0, ram_wr_data=0. This is a harmless read of address 0, and no response is generated.
- prio update: after any grant, prio = the non-granted side. With no grant, prio holds.
  - Both continuously valid -> strict alternation A, B, A, B… when prio starts at A.
- Read response:
  - A read accepted at edge N gives that side's rsp_valid=1 for exactly the cycle after edge N.
  - rsp_data = ram_rd_data, passed straight through during that cycle.
  - rsp_data is don't-care when rsp_valid=0; benches must not check it then.
- Writes produce no response.
- No response back-pressure; requesters must sink responses.
- Back-to-back accesses: one per cycle, any mix.
  - A read granted in the cycle right after a write to the same address returns the new data.
  - A write in cycle N+1 does not corrupt the response of a read accepted at edge N. The RAM registers rd_data at edge N; the write at edge N+1 leaves rd_data untouched.
- Address width is exactly $clog2(DEPTH); there is no out-of-range case.
- rsp_valid is registered. All ram_* outputs and req_ready are combinational; no ram_* output feeds back into another ram_* output or a req_ready.

Test Plan:
- INIT_CLEAR=1, DEPTH=64:
  - Release reset -> ram_wen=1 with ram_addr 0..63 over 64 cycles, ram_wr_data=0.
  - init_done rises on cycle 65; req_ready stays 0 throughout INIT.
- After init:
  - A writes 0xDEAD at addr 5 -> ram_wen=1 that cycle, a_req_ready=1.
  - A reads addr 5 next cycle -> a_rsp_valid=1 one cycle later with a_rsp_data=0xDEAD; b_rsp_valid stays 0.
- Both valid continuously for 6 cycles, prio=A after reset:
  - Grant sequence A,B,A,B,A,B; each side has 3 accepts.
  - Reads to addrs 1 (A) and 2 (B) return the correct data on the matching side only.
- Read-then-write collision:
  - A reads addr 7 (value 0x11) at cycle N; B writes 0x22 to addr 7 at N+1 -> a_rsp_data=0x11.
  - A subsequent read of addr 7 returns 0x22.
- Reset asserted the cycle after a read is accepted -> no rsp_valid; INIT restarts at addr 0.
  - Afterwards, a read of the previously written addr returns 0.
- INIT_CLEAR=0:
  - Right after reset, init_done=1 and a request is accepted in the first cycle.
  - Idle cycles show ram_wen=0 and ram_addr=0.

Source files
------------

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// with an optional post-reset zero-fill of the whole RAM.
module spram_rr_arbiter #(
  parameter int unsigned WIDTH_DATA = 128,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned INIT_CLEAR = 1,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_wen,
  input  logic [AW-1:0]         a_req_addr,
  input  logic [WIDTH_DATA-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [WIDTH_DATA-1:0] a_rsp_data,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_wen,
  input  logic [AW-1:0]         b_req_addr,
  input  logic [WIDTH_DATA-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [WIDTH_DATA-1:0] b_rsp_data,
  output logic                  ram_wen,
  output logic [AW-1:0]         ram_addr,
  output logic [WIDTH_DATA-1:0] ram_wr_data,
  input  logic [WIDTH_DATA-1:0] ram_rd_data,
  output logic                  init_done
);

  typedef enum logic {StInit, StArb} state_e;

  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  logic          prio_q;  // 0: A wins a tie, 1: B wins a tie
  logic          a_rsp_valid_q, b_rsp_valid_q, init_done_q;
  logic          in_arb, grant_a, grant_b;

  always_comb begin
    in_arb      = (state_q == StArb);
    grant_a     = in_arb && a_req_valid && (!b_req_valid || !prio_q);
    grant_b     = in_arb && b_req_valid && (!a_req_valid || prio_q);
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    if (!in_arb) begin
      ram_wen  = 1'b1;
      ram_addr = init_cnt_q;
    end else if (grant_a) begin
      ram_wen     = a_req_wen;
      ram_addr    = a_req_addr;
      ram_wr_data = a_req_wdata;
    end else if (grant_b) begin
      ram_wen     = b_req_wen;
      ram_addr    = b_req_addr;
      ram_wr_data = b_req_wdata;
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  // RAM read data is only meaningful while the matching rsp_valid is high.
  assign a_rsp_data  = ram_rd_data;
  assign b_rsp_data  = ram_rd_data;
  assign init_done   = init_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= (INIT_CLEAR != 0) ? StInit : StArb;
      init_cnt_q    <= '0;
      prio_q        <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      init_done_q   <= (INIT_CLEAR == 0);
    end else begin
      a_rsp_valid_q <= grant_a && !a_req_wen;
      b_rsp_valid_q <= grant_b && !b_req_wen;
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + AW'(1);
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= StArb;
            init_done_q <= 1'b1;
          end
        end
        StArb: begin
          if (grant_a) begin
            prio_q <= 1'b1;
          end else if (grant_b) begin
            prio_q <= 1'b0;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule
